// File: rtl/median_pkg.sv
// Shared definitions for the quickselect median actor chain.
// The middle and last actors use the same state encoding and default constants.
package median_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CALC = 2'd1,
    HDR  = 2'd2,
    EMIT = 2'd3
  } median_state_e;

  localparam logic [10:0] MEDIAN_POS_DEFAULT    = 11'd512;
  localparam logic [10:0] BUFF_SIZE_DEFAULT     = 11'd1024;
  localparam logic [7:0]  DEFAULT_PIVOT_DEFAULT = 8'd127;

  // Wide enough to hold BUFF_SIZE pixels of 255 without overflow.
  localparam int SUM_WIDTH = 8 + $clog2(BUFF_SIZE_DEFAULT);

  function automatic int sumWidth(input int buffSize);
    return 8 + $clog2(buffSize);
  endfunction

endpackage

// File: rtl/median_window_buffer.sv
// Window storage for one raw pixel window: single write port, asynchronous read.
// Contents are not reset; every location is rewritten before it is read.
module median_window_buffer #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             wrEn_i,
  input  logic [IDX_W-1:0] wrIdx_i,
  input  logic [7:0]       wrData_i,
  input  logic [IDX_W-1:0] rdIdx_i,
  output logic [7:0]       rdData_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (wrEn_i) begin
      mem_q[wrIdx_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdIdx_i];

endmodule

// File: rtl/median_first_actor.sv
// Head of the median chain: buffers one window, computes the mean pivot,
// emits the four header tokens, then replays the window on out_px.
module median_first_actor
  import median_pkg::*;
#(
  parameter logic [10:0] MEDIAN_POS     = MEDIAN_POS_DEFAULT,
  parameter logic [10:0] BUFF_SIZE      = BUFF_SIZE_DEFAULT,
  parameter int          BUFF_SIZE_BIT  = $clog2(BUFF_SIZE) + 1,
  parameter logic [7:0]  DEFAULT_PIVOT  = DEFAULT_PIVOT_DEFAULT,
  parameter logic        USE_MEAN_PIVOT = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  output logic [7:0]               out_px,
  output logic                     out_px_wr,
  input  logic                     out_px_full,
  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full
);

  localparam int               IDX_W    = $clog2(BUFF_SIZE);
  localparam int               SUM_W    = sumWidth(int'(BUFF_SIZE));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFF_SIZE - 11'd1);

  median_state_e    state_q, state_d;
  logic [IDX_W-1:0] wrIdx_q, wrIdx_d;
  logic [IDX_W-1:0] rdIdx_q, rdIdx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       pivot_q, pivot_d;
  logic [3:0]       hdrDone_q, hdrDone_d;
  logic [3:0]       hdrWr;
  logic [7:0]       bufRdData;

  median_window_buffer #(
    .DEPTH(int'(BUFF_SIZE)),
    .IDX_W(IDX_W)
  ) u_buffer (
    .clock_i (clock),
    .wrEn_i  (in_px_rd),
    .wrIdx_i (wrIdx_q),
    .wrData_i(in_px),
    .rdIdx_i (rdIdx_q),
    .rdData_o(bufRdData)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FILL;
      wrIdx_q   <= '0;
      rdIdx_q   <= '0;
      sum_q     <= '0;
      pivot_q   <= '0;
      hdrDone_q <= '0;
    end else begin
      state_q   <= state_d;
      wrIdx_q   <= wrIdx_d;
      rdIdx_q   <= rdIdx_d;
      sum_q     <= sum_d;
      pivot_q   <= pivot_d;
      hdrDone_q <= hdrDone_d;
    end
  end

  // Header channels: bit 0 pivot, 1 buff_size, 2 median_pos, 3 second_median_value.
  always_comb begin
    state_d   = state_q;
    wrIdx_d   = wrIdx_q;
    rdIdx_d   = rdIdx_q;
    sum_d     = sum_q;
    pivot_d   = pivot_q;
    hdrDone_d = hdrDone_q;
    hdrWr     = 4'b0000;

    in_px_rd                   = 1'b0;
    out_px                     = 8'd0;
    out_px_wr                  = 1'b0;
    out_pivot                  = 8'd0;
    out_buff_size              = '0;
    out_median_pos             = '0;
    out_second_median_value    = 8'd0;

    unique case (state_q)
      FILL: begin
        in_px_rd = !in_px_empty;
        if (!in_px_empty) begin
          wrIdx_d = wrIdx_q + 1'b1;
          sum_d   = sum_q + SUM_W'(in_px);
          if (wrIdx_q == LAST_IDX) begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        pivot_d   = USE_MEAN_PIVOT ? 8'(sum_q >> IDX_W) : DEFAULT_PIVOT;
        hdrDone_d = 4'b0000;
        state_d   = HDR;
      end

      HDR: begin
        out_pivot               = pivot_q;
        out_buff_size           = BUFF_SIZE_BIT'(BUFF_SIZE);
        out_median_pos          = BUFF_SIZE_BIT'(MEDIAN_POS);
        out_second_median_value = 8'd0;
        hdrWr[0]  = !out_pivot_full               && !hdrDone_q[0];
        hdrWr[1]  = !out_buff_size_full           && !hdrDone_q[1];
        hdrWr[2]  = !out_median_pos_full          && !hdrDone_q[2];
        hdrWr[3]  = !out_second_median_value_full && !hdrDone_q[3];
        hdrDone_d = hdrDone_q | hdrWr;
        if (&hdrDone_d) begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        out_px    = bufRdData;
        out_px_wr = !out_px_full;
        if (!out_px_full) begin
          rdIdx_d = rdIdx_q + 1'b1;
          if (rdIdx_q == LAST_IDX) begin
            state_d = FILL;
            wrIdx_d = '0;
            rdIdx_d = '0;
            sum_d   = '0;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign out_pivot_wr               = hdrWr[0];
  assign out_buff_size_wr           = hdrWr[1];
  assign out_median_pos_wr          = hdrWr[2];
  assign out_second_median_value_wr = hdrWr[3];

endmodule

// File: tb/tb_median_first_actor.sv
// Randomized bench for median_first_actor (16-pixel windows) with a queue-based
// window model; a second instance runs with the fixed default pivot.
module tb_median_first_actor;

  localparam int N = 16;

  logic       clock;
  logic       reset;
  logic [7:0] in_px;
  logic       in_px_rd;
  logic       in_px_empty;
  logic [7:0] out_px;
  logic       out_px_wr;
  logic       out_px_full;
  logic [7:0] out_pivot;
  logic       out_pivot_wr;
  logic       out_pivot_full;
  logic [4:0] out_buff_size;
  logic       out_buff_size_wr;
  logic       out_buff_size_full;
  logic [4:0] out_median_pos;
  logic       out_median_pos_wr;
  logic       out_median_pos_full;
  logic [7:0] out_second_median_value;
  logic       out_second_median_value_wr;
  logic       out_second_median_value_full;

  logic       in_px_rd2;
  logic [7:0] out_px2;
  logic       out_px_wr2;
  logic [7:0] out_pivot2;
  logic       out_pivot_wr2;
  logic [4:0] out_buff_size2;
  logic       out_buff_size_wr2;
  logic [4:0] out_median_pos2;
  logic       out_median_pos_wr2;
  logic [7:0] out_second_median_value2;
  logic       out_second_median_value_wr2;

  median_first_actor #(
    .MEDIAN_POS(11'd8), .BUFF_SIZE(11'd16), .BUFF_SIZE_BIT(5),
    .DEFAULT_PIVOT(8'd127), .USE_MEAN_PIVOT(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
    .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
    .out_pivot(out_pivot), .out_pivot_wr(out_pivot_wr), .out_pivot_full(out_pivot_full),
    .out_buff_size(out_buff_size), .out_buff_size_wr(out_buff_size_wr),
    .out_buff_size_full(out_buff_size_full),
    .out_median_pos(out_median_pos), .out_median_pos_wr(out_median_pos_wr),
    .out_median_pos_full(out_median_pos_full),
    .out_second_median_value(out_second_median_value),
    .out_second_median_value_wr(out_second_median_value_wr),
    .out_second_median_value_full(out_second_median_value_full)
  );

  median_first_actor #(
    .MEDIAN_POS(11'd8), .BUFF_SIZE(11'd16), .BUFF_SIZE_BIT(5),
    .DEFAULT_PIVOT(8'd127), .USE_MEAN_PIVOT(1'b0)
  ) dutFixed (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(in_px_rd2), .in_px_empty(in_px_empty),
    .out_px(out_px2), .out_px_wr(out_px_wr2), .out_px_full(out_px_full),
    .out_pivot(out_pivot2), .out_pivot_wr(out_pivot_wr2), .out_pivot_full(out_pivot_full),
    .out_buff_size(out_buff_size2), .out_buff_size_wr(out_buff_size_wr2),
    .out_buff_size_full(out_buff_size_full),
    .out_median_pos(out_median_pos2), .out_median_pos_wr(out_median_pos_wr2),
    .out_median_pos_full(out_median_pos_full),
    .out_second_median_value(out_second_median_value2),
    .out_second_median_value_wr(out_second_median_value_wr2),
    .out_second_median_value_full(out_second_median_value_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] srcQ[$];
  logic [7:0] curWin[$];
  logic [7:0] expPx[$];
  int         expPivot[$];
  int         pivotLog[$];
  int         pivot2Log[$];
  int         pendSize = 0, pendPos = 0, pendSecond = 0;
  int         lastPopCyc = 0, firstHdr = -1, lastHdr = -1, firstPx = -1;
  int         winSum;
  logic [7:0] popVal;
  bit         anyHdr;

  bit resetReq = 1'b1, inStallEn = 1'b0, pxStallEn = 1'b0, hdrStallEn = 1'b0, holdPivot = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int hdrPending();
    return expPivot.size() + pendSize + pendPos + pendSecond;
  endfunction

  function automatic int outstanding();
    return hdrPending() + expPx.size();
  endfunction

  // Window model: every 16 pops produce one header set and one ordered replay.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      curWin.delete(); expPx.delete(); expPivot.delete();
      pendSize = 0; pendPos = 0; pendSecond = 0;
    end else begin
      if (in_px_rd) checkOutput("rdWhileEmpty", int'(in_px_empty), 0);
      if (in_px_rd && !in_px_empty) begin
        checkOutput("popWhileBusy", outstanding(), 0);
        checkOutput("popSourceNonEmpty", int'(srcQ.size() > 0), 1);
        if (srcQ.size() > 0) begin
          popVal = srcQ.pop_front();
          curWin.push_back(popVal);
          lastPopCyc = cyc;
          if (curWin.size() == N) begin
            winSum = 0;
            foreach (curWin[k]) winSum += int'(curWin[k]);
            expPivot.push_back(winSum / N);
            pendSize++; pendPos++; pendSecond++;
            foreach (curWin[k]) expPx.push_back(curWin[k]);
            curWin.delete();
            firstHdr = -1; lastHdr = -1; firstPx = -1;
          end
        end
      end

      anyHdr = out_pivot_wr || out_buff_size_wr || out_median_pos_wr || out_second_median_value_wr;
      if (anyHdr) begin
        if (firstHdr < 0) begin
          firstHdr = cyc;
          if (!hdrStallEn) checkOutput("hdrLatency", cyc - lastPopCyc, 2);
        end
        lastHdr = cyc;
      end

      if (out_pivot_wr) begin
        checkOutput("pivotWhileFull", int'(out_pivot_full), 0);
        checkOutput("pivotExpected", int'(expPivot.size() > 0), 1);
        if (expPivot.size() > 0) checkOutput("pivotValue", int'(out_pivot), expPivot.pop_front());
        pivotLog.push_back(int'(out_pivot));
        if (holdPivot) checkOutput("pivotHoldDelay", cyc - firstHdr, 10);
      end
      if (out_buff_size_wr) begin
        checkOutput("sizeWhileFull", int'(out_buff_size_full), 0);
        checkOutput("sizeExpected", int'(pendSize > 0), 1);
        checkOutput("sizeValue", int'(out_buff_size), 16);
        if (pendSize > 0) pendSize--;
      end
      if (out_median_pos_wr) begin
        checkOutput("posWhileFull", int'(out_median_pos_full), 0);
        checkOutput("posExpected", int'(pendPos > 0), 1);
        checkOutput("posValue", int'(out_median_pos), 8);
        if (pendPos > 0) pendPos--;
      end
      if (out_second_median_value_wr) begin
        checkOutput("secondWhileFull", int'(out_second_median_value_full), 0);
        checkOutput("secondExpected", int'(pendSecond > 0), 1);
        checkOutput("secondValue", int'(out_second_median_value), 0);
        if (pendSecond > 0) pendSecond--;
      end
      if (out_pivot_wr2) begin
        checkOutput("fixedPivot", int'(out_pivot2), 127);
        pivot2Log.push_back(int'(out_pivot2));
      end

      if (out_px_wr) begin
        checkOutput("pxWhileFull", int'(out_px_full), 0);
        checkOutput("pxBeforeHdrDone", hdrPending(), 0);
        checkOutput("pxExpected", int'(expPx.size() > 0), 1);
        if (expPx.size() > 0) checkOutput("pxValue", int'(out_px), int'(expPx.pop_front()));
        if (firstPx < 0) begin
          firstPx = cyc;
          if (!pxStallEn) checkOutput("emitStart", cyc - lastHdr, 1);
        end
      end
    end
  end

  // Drives all inputs one unit after the rising edge, for the next sampling point.
  task automatic stepCycle();
    int n;
    @(posedge clock);
    #1;
    n = cyc + 1;
    reset = resetReq;
    in_px_empty = resetReq || (srcQ.size() == 0) || (inStallEn && $urandom_range(0, 2) == 0);
    in_px = (srcQ.size() > 0) ? srcQ[0] : 8'd0;
    out_px_full = pxStallEn && ($urandom_range(0, 1) == 0);
    out_pivot_full = (hdrStallEn && $urandom_range(0, 2) == 0) ||
                     (holdPivot && !(firstHdr >= 0 && n >= firstHdr + 10));
    out_buff_size_full = hdrStallEn && $urandom_range(0, 2) == 0;
    out_median_pos_full = hdrStallEn && $urandom_range(0, 2) == 0;
    out_second_median_value_full = hdrStallEn && $urandom_range(0, 2) == 0;
  endtask

  // mode 0: ramp from base, 1: constant base, 2: random pixels.
  task automatic applyStimulus(input int mode, input int base);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: srcQ.push_back(8'(base + i));
        1: srcQ.push_back(8'(base));
        default: srcQ.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic runDrain(input int maxCycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxCycles) begin
      stepCycle();
      n++;
      done = (srcQ.size() == 0) && (curWin.size() == 0) && (outstanding() == 0);
    end
    checkOutput("drainDone", int'(done), 1);
    repeat (5) stepCycle();
  endtask

  function automatic int pivotAt(input int back);
    if (pivotLog.size() <= back) return -1;
    return pivotLog[pivotLog.size() - 1 - back];
  endfunction

  initial begin
    int logBefore;
    reset = 1'b1;
    in_px = 8'd0;
    in_px_empty = 1'b1;
    out_px_full = 1'b0;
    out_pivot_full = 1'b0;
    out_buff_size_full = 1'b0;
    out_median_pos_full = 1'b0;
    out_second_median_value_full = 1'b0;

    repeat (3) stepCycle();
    checkOutput("rstInRd", int'(in_px_rd), 0);
    checkOutput("rstPxWr", int'(out_px_wr), 0);
    checkOutput("rstPx", int'(out_px), 0);
    checkOutput("rstPivotWr", int'(out_pivot_wr), 0);
    checkOutput("rstPivot", int'(out_pivot), 0);
    checkOutput("rstSize", int'(out_buff_size), 0);
    checkOutput("rstPosWr", int'(out_median_pos_wr), 0);
    resetReq = 1'b0;
    stepCycle();

    $display("[TB] ramp window, no backpressure");
    applyStimulus(0, 0);
    runDrain(200);
    checkOutput("rampPivot", pivotAt(0), 7);

    $display("[TB] all-255 window");
    applyStimulus(1, 255);
    runDrain(200);
    checkOutput("satPivot", pivotAt(0), 255);
    checkOutput("fixedPivotCount", pivot2Log.size(), 2);

    $display("[TB] pivot channel held full");
    holdPivot = 1'b1;
    applyStimulus(0, 0);
    runDrain(300);
    holdPivot = 1'b0;
    checkOutput("holdPivot", pivotAt(0), 7);

    $display("[TB] random data with random stalls");
    inStallEn = 1'b1; pxStallEn = 1'b1; hdrStallEn = 1'b1;
    for (int w = 0; w < 4; w++) applyStimulus(2, 0);
    runDrain(4000);
    inStallEn = 1'b0; pxStallEn = 1'b0; hdrStallEn = 1'b0;

    $display("[TB] reset in the middle of a fill");
    for (int i = 0; i < 9; i++) srcQ.push_back(8'(50 + i));
    for (int n = 0; n < 100 && curWin.size() != 9; n++) stepCycle();
    checkOutput("partialFill", curWin.size(), 9);
    logBefore = pivotLog.size();
    resetReq = 1'b1;
    stepCycle();
    resetReq = 1'b0;
    applyStimulus(1, 10);
    runDrain(200);
    checkOutput("resetPivotCount", pivotLog.size() - logBefore, 1);
    checkOutput("resetPivot", pivotAt(0), 10);

    $display("[TB] back-to-back windows");
    applyStimulus(0, 0);
    applyStimulus(1, 200);
    runDrain(400);
    checkOutput("b2bFirstPivot", pivotAt(1), 7);
    checkOutput("b2bSecondPivot", pivotAt(0), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
